// File: rtl/st_req_queue.sv
// Store request queue between LSU issue and the store unit: a small FIFO with a
// zero-latency combinational bypass when empty and a sticky overflow flag.
package st_req_pkg;
    typedef enum logic [7:0] {
        ADD, SD, SW, SH, SB,
        AMO_LRW, AMO_LRD, AMO_SCW, AMO_SCD, AMO_SWAPW, AMO_SWAPD,
        AMO_ADDW, AMO_ADDD, AMO_ANDW, AMO_ORW, AMO_XORW, AMO_MAXW, AMO_MINW
    } fu_op;

    typedef struct packed {
        logic [63:0] vaddr;
        logic [63:0] data;
        logic [7:0]  be;
        fu_op        operation;
        logic [2:0]  trans_id;
        logic [63:0] pc;
        logic [1:0]  rm_cnt;
    } lsu_ctrl_t;

    function automatic logic is_amo(input fu_op op);
        return op inside {AMO_LRW, AMO_LRD, AMO_SCW, AMO_SCD, AMO_SWAPW, AMO_SWAPD,
                          AMO_ADDW, AMO_ADDD, AMO_ANDW, AMO_ORW, AMO_XORW, AMO_MAXW,
                          AMO_MINW};
    endfunction
endpackage

module st_req_queue
    import st_req_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         flush_i,
    input  logic                         valid_i,
    input  lsu_ctrl_t                    lsu_ctrl_i,
    output logic                         ready_o,
    input  logic                         pop_st_i,
    output logic                         valid_o,
    output lsu_ctrl_t                    lsu_ctrl_o,
    output logic [$clog2(DEPTH):0]       count_o,
    output logic                         amo_pending_o,
    output logic                         overflow_o
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    lsu_ctrl_t            mem [DEPTH];
    logic [DEPTH-1:0]     ent_vld_q;
    logic [PTR_W-1:0]     wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]       count_q;
    logic                 overflow_q;
    logic                 empty, full, push_en, pop_en;

    // Handshake: upstream transfers when valid_i & ready_o; downstream retires the
    // head when valid_o & pop_st_i. ready_o comes from registered state only.
    assign empty   = (count_q == '0);
    assign full    = (count_q == FULL_CNT);
    assign ready_o = !full;

    // An empty queue hands the request straight through; if it is popped in the
    // same cycle it never needs a slot.
    assign push_en = valid_i && !full && !(empty && pop_st_i) && !flush_i;
    assign pop_en  = pop_st_i && !empty && !flush_i;

    assign valid_o    = empty ? valid_i : 1'b1;
    assign lsu_ctrl_o = empty ? lsu_ctrl_i : mem[rd_ptr_q];
    assign count_o    = count_q;
    assign overflow_o = overflow_q;

    always_comb begin
        amo_pending_o = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            amo_pending_o = amo_pending_o | (ent_vld_q[i] & is_amo(mem[i].operation));
        end
    end

    // Payload storage carries no reset; entry-valid bits qualify it.
    always_ff @(posedge clk_i) begin
        if (push_en) begin
            mem[wr_ptr_q] <= lsu_ctrl_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            ent_vld_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (valid_i && full) begin
                overflow_q <= 1'b1;
            end
            if (flush_i) begin
                wr_ptr_q  <= '0;
                rd_ptr_q  <= '0;
                count_q   <= '0;
                ent_vld_q <= '0;
            end else begin
                if (pop_en) begin
                    rd_ptr_q            <= rd_ptr_q + PTR_W'(1);
                    ent_vld_q[rd_ptr_q] <= 1'b0;
                end
                if (push_en) begin
                    wr_ptr_q            <= wr_ptr_q + PTR_W'(1);
                    ent_vld_q[wr_ptr_q] <= 1'b1;
                end
                case ({push_en, pop_en})
                    2'b10:   count_q <= count_q + (PTR_W+1)'(1);
                    2'b01:   count_q <= count_q - (PTR_W+1)'(1);
                    default: count_q <= count_q;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_st_req_queue.sv
// Bench for st_req_queue: directed scenarios then random traffic, checked
// against a queue-based model of the request FIFO.
module tb_st_req_queue;
    import st_req_pkg::*;

    localparam int DEPTH = 2;
    localparam int CW    = $bits(lsu_ctrl_t);

    logic       clk, rst_n, flush, valid_in, pop;
    lsu_ctrl_t  ctrl_in, ctrl_out;
    logic       ready_o, valid_o, amo_o, overflow_o;
    logic [1:0] count_o;

    int vectors     = 0;
    int miscompares = 0;

    // Model state: stored entries in FIFO order plus the sticky overflow bit.
    lsu_ctrl_t exp_q[$];
    logic      m_ovf;

    st_req_queue #(.DEPTH(DEPTH)) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .flush_i       (flush),
        .valid_i       (valid_in),
        .lsu_ctrl_i    (ctrl_in),
        .ready_o       (ready_o),
        .pop_st_i      (pop),
        .valid_o       (valid_o),
        .lsu_ctrl_o    (ctrl_out),
        .count_o       (count_o),
        .amo_pending_o (amo_o),
        .overflow_o    (overflow_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [CW-1:0] got, input logic [CW-1:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic op_is_amo(input fu_op op);
        return !(op inside {ADD, SD, SW, SH, SB});
    endfunction

    function automatic lsu_ctrl_t mk(input fu_op op, input logic [2:0] id);
        lsu_ctrl_t r;
        r.vaddr     = {$urandom, $urandom};
        r.data      = {$urandom, $urandom};
        r.be        = 8'($urandom);
        r.operation = op;
        r.trans_id  = id;
        r.pc        = {$urandom, $urandom};
        r.rm_cnt    = 2'($urandom);
        return r;
    endfunction

    function automatic lsu_ctrl_t rnd_req();
        fu_op ops [8] = '{SD, SW, SH, SB, AMO_LRW, AMO_ADDW, AMO_SWAPW, AMO_ADDD};
        return mk(ops[$urandom_range(0, 7)], 3'($urandom));
    endfunction

    task automatic check_all(input string ctx);
        int        n = exp_q.size();
        logic      any_amo = 1'b0;
        lsu_ctrl_t head;
        foreach (exp_q[i]) any_amo |= op_is_amo(exp_q[i].operation);
        head = (n == 0) ? ctrl_in : exp_q[0];
        chk({ctx, " valid_o"}, CW'(valid_o), CW'((n == 0) ? valid_in : 1'b1));
        chk({ctx, " ready_o"}, CW'(ready_o), CW'(n != DEPTH));
        chk({ctx, " count_o"}, CW'(count_o), CW'(n));
        chk({ctx, " amo_pending_o"}, CW'(amo_o), CW'(any_amo));
        chk({ctx, " overflow_o"}, CW'(overflow_o), CW'(m_ovf));
        chk({ctx, " lsu_ctrl_o"}, ctrl_out, head);
    endtask

    task automatic model_update();
        int n = exp_q.size();
        if (valid_in && n == DEPTH) m_ovf = 1'b1;
        if (flush) begin
            exp_q.delete();
        end else begin
            if (pop && n > 0) void'(exp_q.pop_front());
            if (valid_in && n < DEPTH && !(n == 0 && pop)) exp_q.push_back(ctrl_in);
        end
    endtask

    // One clock: drive at negedge, check settled outputs, advance model at posedge.
    task automatic step(input string ctx, input logic v, input lsu_ctrl_t c,
                        input logic p, input logic f);
        @(negedge clk);
        valid_in = v;
        ctrl_in  = c;
        pop      = p;
        flush    = f;
        #1 check_all(ctx);
        @(posedge clk);
        model_update();
    endtask

    task automatic apply_reset(input string ctx);
        @(negedge clk);
        #2;
        valid_in = 1'b0;
        pop      = 1'b0;
        flush    = 1'b0;
        ctrl_in  = rnd_req();
        rst_n    = 1'b0;
        exp_q.delete();
        m_ovf = 1'b0;
        #1 check_all(ctx);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    lsu_ctrl_t idle;

    initial begin
        rst_n    = 1'b0;
        flush    = 1'b0;
        valid_in = 1'b0;
        pop      = 1'b0;
        ctrl_in  = '0;
        m_ovf    = 1'b0;
        idle     = '0;
        repeat (2) @(posedge clk);
        apply_reset("reset");
        step("idle", 1'b0, rnd_req(), 1'b0, 1'b0);

        step("bypass", 1'b1, mk(SD, 3'd3), 1'b1, 1'b0);
        step("after_bypass", 1'b0, idle, 1'b0, 1'b0);

        step("push1", 1'b1, mk(SW, 3'd1), 1'b0, 1'b0);
        step("push2", 1'b1, mk(SD, 3'd2), 1'b0, 1'b0);
        step("full_idle", 1'b0, idle, 1'b0, 1'b0);
        step("pop_head1", 1'b0, idle, 1'b1, 1'b0);
        step("pop_head2", 1'b0, idle, 1'b1, 1'b0);
        step("empty_follow", 1'b1, mk(SB, 3'd5), 1'b0, 1'b0);
        step("drain", 1'b0, idle, 1'b1, 1'b0);

        step("fill_a", 1'b1, mk(SD, 3'd4), 1'b0, 1'b0);
        step("fill_b", 1'b1, mk(SH, 3'd6), 1'b0, 1'b0);
        step("full_push_pop", 1'b1, mk(SW, 3'd7), 1'b1, 1'b0);
        step("ovf_set", 1'b0, idle, 1'b0, 1'b0);
        step("flush_keep_ovf", 1'b0, idle, 1'b0, 1'b1);
        step("ovf_sticky", 1'b0, idle, 1'b0, 1'b0);
        apply_reset("ovf_reset");
        step("ovf_cleared", 1'b0, idle, 1'b0, 1'b0);

        step("push_amo", 1'b1, mk(AMO_ADDW, 3'd1), 1'b0, 1'b0);
        step("push_store", 1'b1, mk(SD, 3'd2), 1'b0, 1'b0);
        step("amo_held", 1'b0, idle, 1'b0, 1'b0);
        step("pop_amo", 1'b0, idle, 1'b1, 1'b0);
        step("store_head", 1'b0, idle, 1'b0, 1'b0);
        step("pop_store", 1'b0, idle, 1'b1, 1'b0);

        step("q_amo", 1'b1, mk(AMO_SWAPW, 3'd2), 1'b0, 1'b0);
        step("q_st", 1'b1, mk(SW, 3'd3), 1'b0, 1'b0);
        step("flush_all", 1'b1, mk(SD, 3'd4), 1'b1, 1'b1);
        step("post_flush", 1'b0, idle, 1'b0, 1'b0);
        step("post_flush_push", 1'b1, mk(AMO_ADDD, 3'd0), 1'b0, 1'b0);
        step("wrap_check", 1'b0, idle, 1'b1, 1'b0);

        step("pre_rst", 1'b1, mk(AMO_LRW, 3'd5), 1'b0, 1'b0);
        apply_reset("async_rst");
        step("after_rst", 1'b0, idle, 1'b0, 1'b0);

        for (int i = 0; i < 400; i++) begin
            step("rand",
                 1'($urandom_range(0, 99) < 60),
                 rnd_req(),
                 1'($urandom_range(0, 99) < 45),
                 1'($urandom_range(0, 99) < 4));
            if (i == 200) apply_reset("rand_rst");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/st_req_queue.md
Name: st_req_queue

Overview:
- Small request queue directly upstream of the store unit.
- Captures store/AMO requests (lsu_ctrl_t) issued by the LSU and presents them one at a time on the store unit's valid_i/lsu_ctrl_i inputs.
- Entries retire when the store unit asserts pop_st_o.
- When empty, the incoming request is bypassed combinationally, so the store unit sees zero added latency.

Parameters:
- DEPTH, 2, number of entries. Must be a power of two and >= 2.
- PTR_W, $clog2(DEPTH), read/write pointer width. Derived; not to be overridden.

Ports:
- clk_i  input  1  clock.
- rst_ni  input  1  asynchronous active-low reset.
- flush_i  input  1  discard all queued requests.
- valid_i  input  1  new request from LSU issue.
- lsu_ctrl_i  input  lsu_ctrl_t  request payload (vaddr, data, be, operation, trans_id, pc, rm_cnt).
- ready_o  output  1  queue can accept a request this cycle.
- pop_st_i  input  1  store unit consumed the head request (its pop_st_o).
- valid_o  output  1  head request valid (drives store unit valid_i).
- lsu_ctrl_o  output  lsu_ctrl_t  head payload (drives store unit lsu_ctrl_i).
- count_o  output  PTR_W+1  number of stored entries, bypass excluded.
- amo_pending_o  output  1  at least one stored entry is an AMO (is_amo(operation)).
- overflow_o  output  1  sticky error: a push was dropped while full.

Behaviour:
- Clock and reset: single clock clk_i. rst_ni is asynchronous, active-low.
- Reset state: pointers 0, count 0, overflow_o=0, all entry valid bits 0. valid_o=0, ready_o=1, amo_pending_o=0. lsu_ctrl_o equals lsu_ctrl_i (bypass path).
- Storage: DEPTH-entry circular buffer with a write pointer, a read pointer, and a count register. Pointers wrap modulo DEPTH via natural PTR_W overflow.
- ready_o = (count_q != DEPTH). It depends on registered state only; there is no combinational path from pop_st_i.
- Output mux:
  - count_q == 0: valid_o = valid_i and lsu_ctrl_o = lsu_ctrl_i (bypass).
  - count_q > 0: valid_o = 1 and lsu_ctrl_o = mem[rd_ptr].
- pop_st_i with valid_o=0 is ignored: no pointer or count change.
- Push (valid_i & ready_o):
  - If count_q == 0 and pop_st_i is asserted the same cycle, the request was consumed via bypass: no write, count unchanged.
  - Otherwise write mem[wr_ptr], then wr_ptr++ and count++.
- Pop (pop_st_i & count_q > 0): rd_ptr++ and count--.
- Simultaneous push and pop with 0 < count_q < DEPTH: write and read both advance; count unchanged.
- Full (count_q == DEPTH):
  - valid_i is not accepted.
  - If valid_i=1 there, overflow_o is set and stays 1 until reset. Upstream must honour ready_o.
  - A pop in the same cycle still retires the head. The dropped push is not retried internally.
- Flush: pointers and count are cleared next cycle, overrides any push/pop in the same cycle. overflow_o is unaffected. valid_o is not gated combinationally by flush_i; the store unit handles same-cycle flush.
- amo_pending_o: OR over stored entries of is_amo(operation) & entry-valid. Entry-valid is set on write and cleared on pop/flush. The bypass entry is not included.
- count_o = count_q, registered.
- Latency: empty queue gives 0 cycles (combinational bypass). Non-empty queue: a pushed request reaches the head after all older entries are popped.
- Order: strictly FIFO; no reordering between stores and AMOs.

Test Plan:
- Reset then idle → valid_o=0, ready_o=1, count_o=0, overflow_o=0.
- Empty queue, valid_i=1 (trans_id=3) with pop_st_i=1 same cycle → valid_o=1, lsu_ctrl_o.trans_id=3 same cycle; next cycle count_o=0.
- Push trans_id 1 and 2 in consecutive cycles with no pop (DEPTH=2) → count_o=2, ready_o=0, head trans_id=1. Pop once → head=2, count_o=1. Pop → count_o=0, valid_o follows valid_i.
- Full queue, valid_i=1 with pop_st_i=1 → head retires, push dropped, overflow_o=1 next cycle; it stays 1 through a later flush and clears only on rst_ni.
- Push an AMO_ADDW then a store; hold pop → amo_pending_o=1. Pop once → amo_pending_o=0, store at head.
- Two entries queued, flush_i=1 with valid_i=1 and pop_st_i=1 same cycle → next cycle count_o=0, amo_pending_o=0, pointers 0. Async rst_ni low mid-operation → all outputs at reset values immediately.
